denise_clut_ctrl: RTL and testbench

Access controller for the Denise AGA colour lookup table. Captures COLORxx register writes into a small FIFO, replays them into `denise_colortable` on 7 MHz slots, and arbitrates a second requester, the palette readback port used by OSD/screenshot logic, onto the table's `rdram` path during blanking only. It sits between the register bus and `denise_colortable`, driving every table control input except `select`.

---
 rtl/denise_clut_pkg.sv | 14 +
 rtl/denise_clut_wr_fifo.sv | 34 +++
 rtl/denise_clut_ctrl.sv | 72 +++++++
 tb/tb_denise_clut_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/denise_clut_pkg.sv
// denise_clut_pkg: shared types for the Denise colour table access controller
package denise_clut_pkg;
  localparam logic [2:0] COLOR_HI = 3'b110;
  typedef struct packed {
    logic [4:0]  addr;
    logic [11:0] data;
    logic [2:0]  bank;
    logic        loct;
  } clut_wr_t;
  typedef enum logic [1:0] {IDLE, RD_A, RD_D, ACK} clut_st_e;
  function automatic logic [11:0] rgb_half(input logic [23:0] rgb, input logic lo);
    return lo ? {rgb[19:16], rgb[11:8], rgb[3:0]} : {rgb[23:20], rgb[15:12], rgb[7:4]};
  endfunction
endpackage

// File: rtl/denise_clut_wr_fifo.sv
// denise_clut_wr_fifo: small FIFO holding captured COLORxx writes until a table slot is free
module denise_clut_wr_fifo
  import denise_clut_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     push,
  input  logic     pop,
  input  clut_wr_t din,
  output logic     full,
  output logic     empty,
  output clut_wr_t head
);
  localparam int AW = $clog2(DEPTH);
  clut_wr_t mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full  = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
  assign head  = mem[rp[AW-1:0]];
  // pointer update; a push into a full FIFO is dropped
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  // entry storage needs no reset: it is only visible while non-empty
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/denise_clut_ctrl.sv
// denise_clut_ctrl: queues COLORxx writes into the colour table and arbitrates palette readback during blanking
module denise_clut_ctrl
  import denise_clut_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk7_en,
  input  logic [8:1]  reg_address_in,
  input  logic [11:0] data_in,
  input  logic [2:0]  bank,
  input  logic        loct,
  input  logic        ehb_en,
  input  logic        blank,
  input  logic        rb_req,
  input  logic [7:0]  rb_idx,
  input  logic        rb_lo,
  output logic        rb_ack,
  output logic [11:0] rb_data,
  output logic [8:1]  ct_reg_address,
  output logic [11:0] ct_data,
  output logic [2:0]  ct_bank,
  output logic        ct_loct,
  output logic        ct_rdram,
  output logic        ct_ehb_en,
  input  logic [23:0] ct_rgb,
  output logic        ovf
);
  clut_st_e st, st_nx;
  clut_wr_t head, din;
  logic full, empty, push, pop, drain, rd, lo_q;
  logic [7:0] idx_q;
  assign din   = '{reg_address_in[5:1], data_in, bank, loct};
  assign push  = clk7_en && reg_address_in[8:6] == COLOR_HI;
  assign drain = st == IDLE && !empty;
  assign pop   = drain && clk7_en;
  assign rd    = st == RD_A || st == RD_D;
  denise_clut_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .din(din),
    .full(full), .empty(empty), .head(head)
  );
  // next state and table drive; pending writes beat a new readback
  always_comb begin
    st_nx = st == IDLE ? ((rb_req && blank && empty) ? RD_A : IDLE) :
            st == RD_A ? RD_D : st == RD_D ? ACK : IDLE;
    rb_ack         = st == ACK;
    ct_rdram       = rd;
    ct_ehb_en      = rd ? 1'b0 : ehb_en;
    ct_reg_address = rd ? {COLOR_HI, idx_q[4:0]} : drain ? {COLOR_HI, head.addr} : 8'h00;
    ct_bank        = rd ? idx_q[7:5] : drain ? head.bank : 3'd0;
    ct_data        = drain ? head.data : 12'h000;
    ct_loct        = drain && head.loct;
  end
  // state register, readback request capture, result and sticky overflow
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st      <= IDLE;
      idx_q   <= '0;
      lo_q    <= 1'b0;
      rb_data <= '0;
      ovf     <= 1'b0;
    end else begin
      st <= st_nx;
      if (st == IDLE && st_nx == RD_A) begin
        idx_q <= rb_idx;
        lo_q  <= rb_lo;
      end
      if (st == RD_D) rb_data <= rgb_half(ct_rgb, lo_q);
      if (push && full) ovf <= 1'b1;
    end
endmodule

// File: tb/tb_denise_clut_ctrl.sv
// tb_denise_clut_ctrl: table-driven and scoreboard checks of the colour table access controller
module tb_denise_clut_ctrl;
  logic clk = 0, reset_n = 1, clk7_en = 0, loct = 0, ehb_en = 0, blank = 0, rb_req = 0, rb_lo = 0;
  logic [8:1] reg_address_in = 0;
  logic [11:0] data_in = 0;
  logic [2:0] bank = 0;
  logic [7:0] rb_idx = 0;
  logic rb_ack, ct_loct, ct_rdram, ct_ehb_en, ovf;
  logic [11:0] rb_data, ct_data;
  logic [8:1] ct_reg_address;
  logic [2:0] ct_bank;
  logic [23:0] ct_rgb = 0, rgb_nx = 0;
  int checks = 0, errors = 0;
  typedef struct {logic [7:0] ca; logic [11:0] d; logic [2:0] bk; logic lc;} tw_t;
  typedef struct {logic [7:0] ra; logic [11:0] d; logic [2:0] bk; logic lc; logic cap; logic [7:0] ca;} vec_t;
  tw_t exp_wr[$];
  logic [11:0] exp_rb[$];
  logic [11:0] thi [256], tlo [256];
  tw_t e;
  logic [7:0] ti;
  logic [11:0] er;

  always #5 clk = ~clk;

  denise_clut_ctrl #(.DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n), .clk7_en(clk7_en), .reg_address_in(reg_address_in),
    .data_in(data_in), .bank(bank), .loct(loct), .ehb_en(ehb_en), .blank(blank),
    .rb_req(rb_req), .rb_idx(rb_idx), .rb_lo(rb_lo), .rb_ack(rb_ack), .rb_data(rb_data),
    .ct_reg_address(ct_reg_address), .ct_data(ct_data), .ct_bank(ct_bank), .ct_loct(ct_loct),
    .ct_rdram(ct_rdram), .ct_ehb_en(ct_ehb_en), .ct_rgb(ct_rgb), .ovf(ovf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] pk(input logic [11:0] h, input logic [11:0] l);
    return {h[11:8], l[11:8], h[7:4], l[7:4], h[3:0], l[3:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  task automatic idle_bus();
    clk7_en = 0;
    reg_address_in = 0;
    data_in = 0;
    bank = 0;
    loct = 0;
  endtask

  task automatic wr(input logic [7:0] ra, input logic [11:0] d, input logic [2:0] bk, input logic lc);
    clk7_en = 1;
    reg_address_in = ra;
    data_in = d;
    bank = bk;
    loct = lc;
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_rdram"}, ct_rdram, 0);
    chk({nm, "_ack"}, rb_ack, 0);
    chk({nm, "_rbdata"}, rb_data, 0);
    chk({nm, "_ovf"}, ovf, 0);
    chk({nm, "_ca"}, ct_reg_address, 0);
    chk({nm, "_data"}, ct_data, 0);
    chk({nm, "_bank"}, ct_bank, 0);
    chk({nm, "_loct"}, ct_loct, 0);
    chk({nm, "_ehb"}, ct_ehb_en, ehb_en);
  endtask

  task automatic readback(input logic [7:0] idx, input logic lo, input logic [11:0] expd, input logic drop_blank);
    int lat;
    lat = -1;
    rb_idx = idx;
    rb_lo = lo;
    blank = 1;
    rb_req = 1;
    exp_rb.push_back(expd);
    for (int i = 0; i < 7; i++) begin
      half();
      if (rb_ack && lat < 0) lat = i;
      step();
      if (i == 0) begin
        rb_req = 0;
        if (drop_blank) blank = 0;
      end
    end
    chk("rb_latency", lat, 3);
    chk("rb_data_hold", rb_data, expd);
  endtask

  // colour table model plus write scoreboard and readback scoreboard
  always @(negedge clk) begin
    if (reset_n && clk7_en && ct_reg_address[8:6] == 3'b110 && !ct_rdram) begin
      ti = {ct_bank, ct_reg_address[5:1]};
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_table_write: got addr %0h data %0h expected none", ct_reg_address, ct_data);
      end else begin
        e = exp_wr.pop_front();
        chk("tw_addr", ct_reg_address, e.ca);
        chk("tw_data", ct_data, e.d);
        chk("tw_bank", ct_bank, e.bk);
        chk("tw_loct", ct_loct, e.lc);
      end
      tlo[ti] = ct_data;
      if (!ct_loct) thi[ti] = ct_data;
    end
    if (rb_ack) begin
      if (exp_rb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rb_ack: got data %0h expected no ack", rb_data);
      end else begin
        er = exp_rb.pop_front();
        chk("rb_data", rb_data, er);
      end
    end
    ti = {ct_bank, ct_reg_address[5:1]};
    rgb_nx = pk(thi[ti], tlo[ti]);
  end

  // registered table read
  always @(posedge clk) ct_rgb <= rgb_nx;

  vec_t vt [6];
  logic seen;

  initial begin
    for (int i = 0; i < 256; i++) begin
      thi[i] = 0;
      tlo[i] = 0;
    end
    vt[0] = '{8'hC1, 12'hABC, 3'd1, 1'b0, 1'b1, 8'hC1};
    vt[1] = '{8'hC1, 12'h123, 3'd1, 1'b1, 1'b1, 8'hC1};
    vt[2] = '{8'hDF, 12'hFFF, 3'd7, 1'b0, 1'b1, 8'hDF};
    vt[3] = '{8'hC0, 12'h5A5, 3'd0, 1'b0, 1'b1, 8'hC0};
    vt[4] = '{8'h80, 12'h999, 3'd3, 1'b1, 1'b0, 8'h00};
    vt[5] = '{8'hE0, 12'h777, 3'd2, 1'b0, 1'b0, 8'h00};

    #1 reset_n = 0;
    half();
    chk_reset_outs("reset");
    ehb_en = 1;
    #1 chk("reset_ehb_follow", ct_ehb_en, 1);
    ehb_en = 0;
    step();
    reset_n = 1;
    step();

    foreach (vt[k]) begin
      wr(vt[k].ra, vt[k].d, vt[k].bk, vt[k].lc);
      if (vt[k].cap) exp_wr.push_back('{vt[k].ca, vt[k].d, vt[k].bk, vt[k].lc});
      half();
      step();
      idle_bus();
      half();
      chk("vec_ca", ct_reg_address, vt[k].ca);
      chk("vec_data", ct_data, vt[k].cap ? vt[k].d : 12'h000);
      chk("vec_bank", ct_bank, vt[k].cap ? vt[k].bk : 3'd0);
      chk("vec_loct", ct_loct, vt[k].cap && vt[k].lc);
      chk("vec_rdram", ct_rdram, 0);
      step();
      clk7_en = 1;
      half();
      step();
      clk7_en = 0;
      half();
      chk("vec_after_pop", ct_reg_address, 0);
      step();
    end

    readback(8'd33, 1'b0, 12'hABC, 1'b0);
    readback(8'd33, 1'b1, 12'h123, 1'b0);
    readback(8'd255, 1'b1, 12'hFFF, 1'b0);
    readback(8'd0, 1'b0, 12'h5A5, 1'b0);

    rb_idx = 8'd255;
    rb_lo = 0;
    blank = 0;
    rb_req = 1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      half();
      seen = seen | ct_rdram | rb_ack;
      step();
    end
    chk("noblank_no_access", seen, 0);
    readback(8'd255, 1'b0, 12'hFFF, 1'b1);

    ehb_en = 1;
    rb_idx = 8'd0;
    rb_lo = 0;
    blank = 1;
    rb_req = 1;
    exp_rb.push_back(12'h5A5);
    wr(8'hC2, 12'h777, 3'd2, 1'b0);
    exp_wr.push_back('{8'hC2, 12'h777, 3'd2, 1'b0});
    half();
    chk("rda_idle_ca", ct_reg_address, 0);
    step();
    idle_bus();
    clk7_en = 1;
    rb_req = 0;
    half();
    chk("rda_rdram", ct_rdram, 1);
    chk("rda_ca", ct_reg_address, 8'hC0);
    chk("rda_ehb", ct_ehb_en, 0);
    step();
    half();
    chk("rdd_no_drain", ct_reg_address, 8'hC0);
    chk("rdd_ack", rb_ack, 0);
    step();
    clk7_en = 0;
    half();
    chk("ack_pulse", rb_ack, 1);
    chk("ack_ca", ct_reg_address, 0);
    step();
    clk7_en = 1;
    half();
    chk("after_ack_ca", ct_reg_address, 8'hC2);
    chk("after_ack_data", ct_data, 12'h777);
    chk("after_ack_ehb", ct_ehb_en, 1);
    chk("after_ack_ackl", rb_ack, 0);
    step();
    clk7_en = 0;
    half();
    chk("queued_popped", ct_reg_address, 0);
    chk("queued_no_ovf", ovf, 0);
    step();
    ehb_en = 0;

    rb_idx = 8'd33;
    rb_lo = 1;
    blank = 1;
    rb_req = 1;
    exp_rb.push_back(12'h123);
    half();
    step();
    rb_req = 0;
    wr(8'hC3, 12'h111, 3'd0, 1'b0);
    exp_wr.push_back('{8'hC3, 12'h111, 3'd0, 1'b0});
    half();
    chk("ovf_a", ovf, 0);
    step();
    wr(8'hC4, 12'h222, 3'd0, 1'b0);
    exp_wr.push_back('{8'hC4, 12'h222, 3'd0, 1'b0});
    half();
    chk("ovf_b", ovf, 0);
    step();
    wr(8'hC5, 12'h333, 3'd0, 1'b0);
    half();
    step();
    idle_bus();
    clk7_en = 1;
    half();
    chk("ovf_set", ovf, 1);
    chk("ovf_head_a", ct_reg_address, 8'hC3);
    step();
    half();
    chk("ovf_head_b", ct_reg_address, 8'hC4);
    step();
    clk7_en = 0;
    half();
    chk("ovf_third_dropped", ct_reg_address, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      half();
    end
    chk("ovf_sticky", ovf, 1);
    step();

    rb_idx = 8'd255;
    rb_lo = 0;
    blank = 1;
    rb_req = 1;
    half();
    step();
    rb_req = 0;
    wr(8'hC6, 12'h444, 3'd0, 1'b0);
    half();
    step();
    idle_bus();
    half();
    chk("pre_reset_rdd", ct_rdram, 1);
    #1 reset_n = 0;
    ehb_en = 1;
    #1 chk_reset_outs("rst_rdd");
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      half();
      seen = seen | rb_ack;
      step();
    end
    reset_n = 1;
    ehb_en = 0;
    for (int i = 0; i < 6; i++) begin
      clk7_en = 1;
      half();
      seen = seen | rb_ack | (ct_reg_address != 0);
      step();
    end
    idle_bus();
    chk("rst_no_ack_fifo_empty", seen, 0);
    half();
    chk("rst_rbdata_zero", rb_data, 0);
    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("rb_queue_empty", exp_rb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
